// File: rtl/flick_if.sv
// Flick button signal group: raw button level in, conditioned pulse/level/long-press out.
interface flick_if;
  logic flick_raw;
  logic flick_pulse;
  logic flick_level;
  logic long_press;

  modport master (
    output flick_raw,
    input  flick_pulse,
    input  flick_level,
    input  long_press
  );

  modport slave (
    input  flick_raw,
    output flick_pulse,
    output flick_level,
    output long_press
  );
endinterface

// File: rtl/flick_conditioner.sv
// Synchronises and debounces the raw flick button; emits a one-cycle flick pulse,
// a debounced level and a one-shot long-press event.
//
// state        | meaning
// IDLE         | button released and accepted as released
// PRESS_WAIT   | sync_q high, counting stable samples before accepting the press
// PRESSED      | press accepted, counting towards long_press
// RELEASE_WAIT | sync_q low during a press, counting stable samples before accepting release
module flick_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 32,
  parameter int CNT_W           = 16
) (
  input  logic    clk,
  input  logic    rst,
  flick_if.slave  fif
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic             sync_d;
  logic             sync_q;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pulse_q, pulse_n;
  logic             level_q, level_n;
  logic             long_q, long_n;
  logic             long_done, long_done_n;

  // Two-flop synchroniser; flick_raw is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_d <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sync_d <= fif.flick_raw;
      sync_q <= sync_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pulse_q   <= 1'b0;
      level_q   <= 1'b0;
      long_q    <= 1'b0;
      long_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pulse_q   <= pulse_n;
      level_q   <= level_n;
      long_q    <= long_n;
      long_done <= long_done_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pulse_n     = 1'b0;
    level_n     = level_q;
    long_n      = 1'b0;
    long_done_n = long_done;

    unique case (state)
      IDLE: begin
        long_done_n = 1'b0;
        cnt_n       = '0;
        if (sync_q) begin
          state_n = PRESS_WAIT;
        end
      end

      PRESS_WAIT: begin
        if (!sync_q) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          pulse_n = 1'b1;
          level_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      PRESSED: begin
        if (!sync_q) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end else if (cnt < HOLD_MAX) begin
          cnt_n = cnt + 1'b1;
          // long_done survives a bounce back from RELEASE_WAIT so the event stays one-shot.
          if (cnt == HOLD_LAST && !long_done) begin
            long_n      = 1'b1;
            long_done_n = 1'b1;
          end
        end
      end

      RELEASE_WAIT: begin
        if (sync_q) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          level_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign fif.flick_pulse = pulse_q;
  assign fif.flick_level = level_q;
  assign fif.long_press  = long_q;

endmodule

// File: tb/tb_flick_conditioner.sv
// Directed bench for flick_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=32.
module tb_flick_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;

  flick_if fif ();

  flick_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (32),
    .CNT_W           (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Step n applies flick_raw before edge n; outputs are read 1 time unit after edge n.
  int stepno;
  int pulse_cnt, pulse_at;
  int long_cnt, long_at;

  task automatic clear_mon();
    stepno    = 0;
    pulse_cnt = 0;
    pulse_at  = -1;
    long_cnt  = 0;
    long_at   = -1;
  endtask

  task automatic step(input logic r);
    fif.flick_raw = r;
    @(posedge clk);
    #1;
    stepno++;
    if (fif.flick_pulse === 1'b1) begin
      pulse_cnt++;
      pulse_at = stepno;
    end
    if (fif.long_press === 1'b1) begin
      long_cnt++;
      long_at = stepno;
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic test_reset();
    logic [2:0] obs;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      obs = {fif.flick_pulse, fif.flick_level, fif.long_press};
      vectors++;
      if (obs !== 3'b000) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %b want 000", i, obs);
      end
    end
    rst = 1'b0;
    clear_mon();
    for (int j = 1; j <= 12; j++) step(1'b1);
    vectors++;
    if (pulse_cnt !== 1) begin
      errors++;
      $display("FAIL reset_release_pulse_count: got %0d want 1", pulse_cnt);
    end
    vectors++;
    if (pulse_at !== 7) begin
      errors++;
      $display("FAIL reset_release_pulse_edge: got %0d want 7", pulse_at);
    end
    vectors++;
    if (fif.flick_level !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_level: got %b want 1", fif.flick_level);
    end
    settle(12);
    vectors++;
    if (fif.flick_level !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_level_drop: got %b want 0", fif.flick_level);
    end
  endtask

  task automatic test_basic_press();
    logic lvl12, lvl13;
    clear_mon();
    lvl12 = 1'bx;
    lvl13 = 1'bx;
    for (int j = 1; j <= 20; j++) begin
      step(j <= 6);
      if (j == 12) lvl12 = fif.flick_level;
      if (j == 13) lvl13 = fif.flick_level;
    end
    vectors++;
    if (pulse_cnt !== 1 || pulse_at !== 7) begin
      errors++;
      $display("FAIL basic_pulse: got count %0d at %0d want count 1 at 7", pulse_cnt, pulse_at);
    end
    vectors++;
    if (lvl12 !== 1'b1) begin
      errors++;
      $display("FAIL basic_level_held: got %b want 1", lvl12);
    end
    vectors++;
    if (lvl13 !== 1'b0) begin
      errors++;
      $display("FAIL basic_level_fall: got %b want 0", lvl13);
    end
    vectors++;
    if (long_cnt !== 0) begin
      errors++;
      $display("FAIL basic_no_long: got %0d want 0", long_cnt);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] burst;
    burst = 6'b101101;
    clear_mon();
    for (int j = 1; j <= 20; j++) begin
      if (j <= 6) step(burst[6-j]);
      else        step(1'b1);
    end
    vectors++;
    if (pulse_cnt !== 1 || pulse_at !== 12) begin
      errors++;
      $display("FAIL bounce_pulse: got count %0d at %0d want count 1 at 12", pulse_cnt, pulse_at);
    end
    vectors++;
    if (fif.flick_level !== 1'b1) begin
      errors++;
      $display("FAIL bounce_level: got %b want 1", fif.flick_level);
    end
    settle(12);
  endtask

  task automatic test_glitch_reject();
    int lvl_hi;
    clear_mon();
    lvl_hi = 0;
    for (int j = 1; j <= 23; j++) begin
      step(j <= 3);
      if (fif.flick_level !== 1'b0) lvl_hi++;
    end
    vectors++;
    if (pulse_cnt !== 0 || lvl_hi !== 0 || long_cnt !== 0) begin
      errors++;
      $display("FAIL glitch_reject: got pulses %0d level_hi %0d longs %0d want 0 0 0",
               pulse_cnt, lvl_hi, long_cnt);
    end
  endtask

  task automatic test_debounce_boundary();
    // 4 raw-high cycles give only 4 sync_q samples after leaving IDLE; 5 are needed.
    clear_mon();
    for (int j = 1; j <= 19; j++) step(j <= 4);
    vectors++;
    if (pulse_cnt !== 0 || fif.flick_level !== 1'b0) begin
      errors++;
      $display("FAIL boundary_high4: got pulses %0d level %b want 0 0", pulse_cnt, fif.flick_level);
    end
    clear_mon();
    for (int j = 1; j <= 19; j++) step(j <= 5);
    vectors++;
    if (pulse_cnt !== 1 || pulse_at !== 7) begin
      errors++;
      $display("FAIL boundary_high5: got count %0d at %0d want count 1 at 7", pulse_cnt, pulse_at);
    end
  endtask

  task automatic test_long_hold();
    int lvl_lo;
    logic lvl67;
    clear_mon();
    lvl_lo = 0;
    lvl67  = 1'bx;
    for (int j = 1; j <= 75; j++) begin
      step(j <= 60 && j != 45 && j != 46);
      if (j >= 7 && j <= 66 && fif.flick_level !== 1'b1) lvl_lo++;
      if (j == 67) lvl67 = fif.flick_level;
    end
    vectors++;
    if (pulse_cnt !== 1 || pulse_at !== 7) begin
      errors++;
      $display("FAIL long_pulse: got count %0d at %0d want count 1 at 7", pulse_cnt, pulse_at);
    end
    vectors++;
    if (long_cnt !== 1 || long_at !== 39) begin
      errors++;
      $display("FAIL long_press_event: got count %0d at %0d want count 1 at 39", long_cnt, long_at);
    end
    vectors++;
    if (lvl_lo !== 0) begin
      errors++;
      $display("FAIL long_level_glitch: got %0d low cycles want 0", lvl_lo);
    end
    vectors++;
    if (lvl67 !== 1'b0) begin
      errors++;
      $display("FAIL long_level_fall: got %b want 0", lvl67);
    end
  endtask

  task automatic test_back_to_back();
    int lvl_lo;
    clear_mon();
    lvl_lo = 0;
    for (int j = 1; j <= 40; j++) begin
      step((j <= 10) || (j >= 15 && j <= 20) || (j >= 26));
      if (j >= 8 && fif.flick_level !== 1'b1) lvl_lo++;
    end
    vectors++;
    if (pulse_cnt !== 2 || pulse_at !== 32) begin
      errors++;
      $display("FAIL repress_pulses: got count %0d last at %0d want count 2 last at 32",
               pulse_cnt, pulse_at);
    end
    vectors++;
    if (lvl_lo !== 5) begin
      errors++;
      $display("FAIL repress_level_low: got %0d low cycles want 5", lvl_lo);
    end
    vectors++;
    if (long_cnt !== 0) begin
      errors++;
      $display("FAIL repress_no_long: got %0d want 0", long_cnt);
    end
    settle(12);
  endtask

  task automatic test_reset_mid_press();
    logic [2:0] obs;
    clear_mon();
    for (int j = 1; j <= 10; j++) step(1'b1);
    vectors++;
    if (fif.flick_level !== 1'b1 || pulse_cnt !== 1) begin
      errors++;
      $display("FAIL midpress_setup: got level %b pulses %0d want 1 1", fif.flick_level, pulse_cnt);
    end
    rst = 1'b1;
    step(1'b1);
    obs = {fif.flick_pulse, fif.flick_level, fif.long_press};
    vectors++;
    if (obs !== 3'b000) begin
      errors++;
      $display("FAIL midpress_reset_outputs: got %b want 000", obs);
    end
    step(1'b1);
    rst = 1'b0;
    clear_mon();
    for (int j = 1; j <= 12; j++) step(1'b1);
    vectors++;
    if (pulse_cnt !== 1 || pulse_at !== 7) begin
      errors++;
      $display("FAIL midpress_repulse: got count %0d at %0d want count 1 at 7", pulse_cnt, pulse_at);
    end
    settle(12);
    vectors++;
    if (fif.flick_level !== 1'b0) begin
      errors++;
      $display("FAIL midpress_final_release: got %b want 0", fif.flick_level);
    end
  endtask

  initial begin
    fif.flick_raw = 1'b1;
    clear_mon();
    test_reset();
    test_basic_press();
    test_bounce();
    test_glitch_reject();
    test_debounce_boundary();
    test_long_hold();
    test_back_to_back();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
